// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: per-window scheduler for the KxK convolution datapath, issuing fmap reads,
// latency-aligned tap strobes, a MAC clock-enable and a backpressured output write.
module conv_window_sequencer #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int K      = 3,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              kernel_ready,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              fmap_en,
    output logic [ADDR_W-1:0] fmap_addr,
    output logic              tap_valid,
    output logic [3:0]        tap_idx,
    output logic              mac_ce,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ACC, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - K);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W - K + 1);
    localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [3:0]        KX_LAST    = 4'(K - 1);
    localparam logic [3:0]        TAP_LAST   = 4'(K * K - 1);
    localparam logic [7:0]        DRAIN_LAST = 8'(RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] row, col, base, win, next_base;
    logic [3:0]        tap, kx;
    logic [7:0]        drain;
    logic              last_win;
    logic [RD_LAT-1:0] vpipe;
    logic [3:0]        ipipe [RD_LAT];

    // base tracks row*IMG_W+col; wrapping from the last column lands on the next row start
    assign next_base = base + ((col == COL_LAST) ? WRAP_STEP : ONE);
    assign last_win  = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fmap_en   <= 1'b0;
            fmap_addr <= '0;
            mac_ce    <= 1'b0;
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            row       <= '0;
            col       <= '0;
            base      <= '0;
            win       <= '0;
            tap       <= '0;
            kx        <= '0;
            drain     <= '0;
        end else begin
            done   <= 1'b0;
            mac_ce <= 1'b0;
            case (state)
                S_IDLE: if (start && kernel_ready) begin
                    state     <= S_ISSUE;
                    busy      <= 1'b1;
                    fmap_en   <= 1'b1;
                    fmap_addr <= base;
                    tap       <= '0;
                    kx        <= '0;
                end
                S_ISSUE: if (tap == TAP_LAST) begin
                    state   <= S_DRAIN;
                    fmap_en <= 1'b0;
                    drain   <= '0;
                end else begin
                    tap       <= tap + 4'd1;
                    kx        <= (kx == KX_LAST) ? 4'd0 : kx + 4'd1;
                    fmap_addr <= fmap_addr + ((kx == KX_LAST) ? ROW_STEP : ONE);
                end
                S_DRAIN: if (drain == DRAIN_LAST) begin
                    state  <= S_ACC;
                    mac_ce <= 1'b1;
                end else begin
                    drain <= drain + 8'd1;
                end
                S_ACC: begin
                    state     <= S_WRITE;
                    out_wr_en <= 1'b1;
                    out_addr  <= win;
                end
                S_WRITE: if (out_ready) begin
                    out_wr_en <= 1'b0;
                    if (last_win) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        base  <= '0;
                        win   <= '0;
                    end else begin
                        state     <= S_ISSUE;
                        fmap_en   <= 1'b1;
                        fmap_addr <= next_base;
                        base      <= next_base;
                        tap       <= '0;
                        kx        <= '0;
                        win       <= win + ONE;
                        row       <= (col == COL_LAST) ? row + ONE : row;
                        col       <= (col == COL_LAST) ? '0 : col + ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // issue strobe and slot delayed by the BRAM read latency so taps line up with douta
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++) ipipe[i] <= '0;
        end else begin
            vpipe[0] <= fmap_en;
            ipipe[0] <= fmap_en ? tap : 4'd0;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                ipipe[i] <= ipipe[i-1];
            end
        end
    end

    assign tap_valid = vpipe[RD_LAT-1];
    assign tap_idx   = ipipe[RD_LAT-1];
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: default-size instance for addressing, backpressure and reset cases;
// a 5x4 instance for whole frames and randomized runs against a window-level reference model.
module tb_conv_window_sequencer;
    localparam int AW = 16;
    localparam int SW = 5, SH = 4, KK = 3;
    localparam int SCOLS = SW - KK + 1;
    localparam int SWIN = SCOLS * (SH - KK + 1);

    logic clk = 0, reset = 0;
    logic start = 0, kernel_ready = 0, out_ready = 0;
    logic busy, done, fmap_en, tap_valid, mac_ce, out_wr_en;
    logic [AW-1:0] fmap_addr, out_addr;
    logic [3:0] tap_idx;
    logic s_start = 0, s_kr = 0, s_or = 0;
    logic s_busy, s_done, s_fe, s_tv, s_mac, s_we;
    logic [AW-1:0] s_fa, s_oa;
    logic [3:0] s_ti;

    int passed = 0, total = 0;

    typedef struct {
        logic st, kr, ordy;
        logic fe; logic [15:0] fa; logic tv; logic [3:0] ti;
        logic mc; logic we; logic [15:0] oa; logic bz;
    } vec_t;
    vec_t tbl [14];
    int first_addr [9] = '{0, 1, 2, 224, 225, 226, 448, 449, 450};
    int bases [6] = '{0, 1, 2, 5, 6, 7};

    logic [15:0] exp_fa [$];
    logic [15:0] exp_oa [$];
    int n, nw, nb, done_at, ndone, frames, issued, t0, tv_count, wif;
    logic pfe, pf1, pf2, prev_we, prev_or;
    logic [15:0] last_fa, prev_oa;

    conv_window_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .kernel_ready(kernel_ready), .out_ready(out_ready),
        .busy(busy), .done(done), .fmap_en(fmap_en), .fmap_addr(fmap_addr), .tap_valid(tap_valid),
        .tap_idx(tap_idx), .mac_ce(mac_ce), .out_wr_en(out_wr_en), .out_addr(out_addr)
    );

    conv_window_sequencer #(.IMG_W(SW), .IMG_H(SH), .K(KK)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .kernel_ready(s_kr), .out_ready(s_or),
        .busy(s_busy), .done(s_done), .fmap_en(s_fe), .fmap_addr(s_fa), .tap_valid(s_tv),
        .tap_idx(s_ti), .mac_ce(s_mac), .out_wr_en(s_we), .out_addr(s_oa)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic any_out();
        return |{busy, done, fmap_en, fmap_addr, tap_valid, tap_idx, mac_ce, out_wr_en, out_addr};
    endfunction

    function automatic logic s_any();
        return |{s_busy, s_done, s_fe, s_fa, s_tv, s_ti, s_mac, s_we, s_oa};
    endfunction

    // returns positioned on the first issue cycle of window w+1
    task automatic wait_write(input int w);
        int k = 0;
        while (!(out_wr_en && out_ready && out_addr == AW'(w)) && k < 20000) begin
            step();
            k++;
        end
        chk($sformatf("reach window %0d", w + 1), 32'(k < 20000), 1);
        step();
    endtask

    initial begin
        for (int j = 0; j < 14; j++) begin
            tbl[j].st = (j == 0); tbl[j].kr = 1'b1; tbl[j].ordy = 1'b1;
            tbl[j].fe = (j < 9) || (j == 13);
            tbl[j].fa = (j < 9) ? 16'(first_addr[j]) : 16'd1;
            tbl[j].tv = (j >= 2) && (j <= 10);
            tbl[j].ti = tbl[j].tv ? 4'(j - 2) : 4'd0;
            tbl[j].mc = (j == 11); tbl[j].we = (j == 12); tbl[j].oa = 16'd0; tbl[j].bz = 1'b1;
        end

        out_ready = 1;
        repeat (3) begin
            step();
            chk("reset outputs", 32'(any_out()), 0);
            chk("reset outputs small", 32'(s_any()), 0);
        end
        reset = 1;
        repeat (10) begin
            step();
            chk("idle outputs", 32'(any_out()), 0);
        end
        start = 1; kernel_ready = 0;
        repeat (5) begin
            step();
            chk("start without kernel_ready", 32'(busy), 0);
        end

        for (int j = 0; j < 14; j++) begin
            start = tbl[j].st; kernel_ready = tbl[j].kr; out_ready = tbl[j].ordy;
            step();
            chk($sformatf("w0[%0d] fmap_en", j), 32'(fmap_en), 32'(tbl[j].fe));
            if (tbl[j].fe) chk($sformatf("w0[%0d] fmap_addr", j), 32'(fmap_addr), 32'(tbl[j].fa));
            chk($sformatf("w0[%0d] tap_valid", j), 32'(tap_valid), 32'(tbl[j].tv));
            if (tbl[j].tv) chk($sformatf("w0[%0d] tap_idx", j), 32'(tap_idx), 32'(tbl[j].ti));
            chk($sformatf("w0[%0d] mac_ce", j), 32'(mac_ce), 32'(tbl[j].mc));
            chk($sformatf("w0[%0d] out_wr_en", j), 32'(out_wr_en), 32'(tbl[j].we));
            if (tbl[j].we) chk($sformatf("w0[%0d] out_addr", j), 32'(out_addr), 32'(tbl[j].oa));
            chk($sformatf("w0[%0d] busy", j), 32'(busy), 32'(tbl[j].bz));
        end

        wait_write(2);
        for (int j = 0; j < 30; j++) begin
            out_ready = !(j >= 12 && j <= 15);
            if (j <= 8) chk($sformatf("bp w3 addr %0d", j), 32'(fmap_addr), 32'(3 + (j / 3) * 224 + j % 3));
            if (j >= 12 && j <= 16) begin
                chk("bp hold out_wr_en", 32'(out_wr_en), 1);
                chk("bp hold out_addr", 32'(out_addr), 3);
                chk("bp no issue while stalled", 32'(fmap_en), 0);
            end
            if (j == 17) begin
                chk("bp w4 fmap_en", 32'(fmap_en), 1);
                chk("bp w4 base", 32'(fmap_addr), 4);
            end
            if (j == 28) chk("bp w4 mac_ce", 32'(mac_ce), 1);
            if (j == 29) begin
                chk("bp w4 out_wr_en", 32'(out_wr_en), 1);
                chk("bp w4 out_addr", 32'(out_addr), 4);
            end
            step();
        end

        wait_write(9);
        repeat (9) step();
        chk("w10 drain tap_valid", 32'(tap_valid), 1);
        reset = 0;
        #1;
        chk("async reset clears outputs", 32'(any_out()), 0);
        start = 1; kernel_ready = 1;
        repeat (2) step();
        chk("outputs held in reset", 32'(any_out()), 0);
        reset = 1;
        step();
        chk("restart fmap_en", 32'(fmap_en), 1);
        chk("restart fmap_addr", 32'(fmap_addr), 0);
        chk("restart busy", 32'(busy), 1);
        start = 0;
        repeat (12) step();
        chk("restart out_wr_en", 32'(out_wr_en), 1);
        chk("restart out_addr", 32'(out_addr), 0);

        wait_write(220);
        chk("w221 fmap_en", 32'(fmap_en), 1);
        chk("w221 base", 32'(fmap_addr), 221);
        wait_write(221);
        chk("w222 base after row wrap", 32'(fmap_addr), 224);
        repeat (8) step();
        chk("w222 last tap addr", 32'(fmap_addr), 674);
        repeat (4) step();
        chk("w222 out_wr_en", 32'(out_wr_en), 1);
        chk("w222 out_addr", 32'(out_addr), 222);

        s_start = 1; s_kr = 1; s_or = 1;
        step();
        nw = 0; nb = 0; done_at = -1; ndone = 0; pfe = 0; last_fa = 0;
        for (int j = 0; j <= 80; j++) begin
            if (j < 78) begin
                if (s_fe && !pfe) begin
                    chk($sformatf("small base %0d", nb), 32'(s_fa), (nb < 6) ? 32'(bases[nb]) : 32'hFFFF_FFFF);
                    nb++;
                end
                if (s_fe) last_fa = s_fa;
                if (s_we) begin
                    chk($sformatf("small out_addr %0d", nw), 32'(s_oa), 32'(nw));
                    nw++;
                end
            end
            if (s_done) begin
                ndone++;
                done_at = j;
            end
            if (j == 79) chk("small busy low in idle", 32'(s_busy), 0);
            if (j == 80) begin
                chk("held start restarts fmap_en", 32'(s_fe), 1);
                chk("held start restarts at 0", 32'(s_fa), 0);
            end
            pfe = s_fe;
            if (j < 80) step();
        end
        chk("small write count", 32'(nw), 6);
        chk("small window count", 32'(nb), 6);
        chk("small last tap addr", 32'(last_fa), 19);
        chk("small done cycle", 32'(done_at), 78);
        chk("small done pulses", 32'(ndone), 1);
        s_start = 0;
        n = 0;
        while (!s_done && n < 200) begin
            step();
            n++;
        end
        chk("second small frame done", 32'(n < 200), 1);
        step();

        for (int f = 0; f < 4; f++)
            for (int w = 0; w < SWIN; w++) begin
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++)
                        exp_fa.push_back(16'(((w / SCOLS) + ky) * SW + (w % SCOLS) + kx));
                exp_oa.push_back(16'(w));
            end
        s_start = 1;
        n = 0; frames = 0; issued = 0; t0 = 0; tv_count = 0; wif = 0;
        pf1 = 0; pf2 = 0; prev_we = 0; prev_or = 0; prev_oa = 0;
        while (frames < 4 && n < 4000) begin
            s_kr = ($urandom_range(0, 3) != 0);
            s_or = ($urandom_range(0, 2) != 0);
            chk("rnd tap_valid delay", 32'(s_tv), 32'(pf2));
            if (s_tv) begin
                chk("rnd tap_idx", 32'(s_ti), 32'(tv_count % 9));
                tv_count++;
            end
            if (s_fe) begin
                chk("rnd fmap_addr", 32'(s_fa), (exp_fa.size() > 0) ? 32'(exp_fa.pop_front()) : 32'hFFFF_FFFF);
                if (issued % 9 == 0) t0 = n;
                issued++;
            end
            if (s_we) chk("rnd no issue during write", 32'(s_fe), 0);
            if (s_we && !prev_we) chk("rnd window latency", 32'(n - t0), 12);
            if (prev_we && !prev_or) begin
                chk("rnd stall holds out_wr_en", 32'(s_we), 1);
                chk("rnd stall holds out_addr", 32'(s_oa), 32'(prev_oa));
            end
            if (s_we && s_or) begin
                chk("rnd out_addr", 32'(s_oa), (exp_oa.size() > 0) ? 32'(exp_oa.pop_front()) : 32'hFFFF_FFFF);
                wif++;
            end
            if (s_done) begin
                chk("rnd writes per frame", 32'(wif), 32'(SWIN));
                wif = 0;
                frames++;
                if (frames == 4) s_start = 0;
            end
            pf2 = pf1; pf1 = s_fe; prev_we = s_we; prev_or = s_or; prev_oa = s_oa;
            step();
            n++;
        end
        chk("rnd frames completed", 32'(frames), 4);
        chk("rnd fmap queue drained", 32'(exp_fa.size()), 0);
        chk("rnd write queue drained", 32'(exp_oa.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Frame-level controller for the 3x3 convolution datapath.
- Generates feature-map BRAM read addresses for every sliding window.
- Tracks BRAM read latency and emits aligned tap strobes that load the 9-entry patch register file.
- Pulses the DSP clock-enable once per window, then issues the output BRAM write with backpressure. It replaces ad-hoc per-patch address arithmetic with a single scheduler between the host start/done handshake and the MAC array.

Parameters:
- IMG_W, 224, feature-map width in pixels.
- IMG_H, 224, feature-map height in pixels.
- K, 3, kernel edge; taps per window = K*K.
- ADDR_W, 16, width of fmap and output addresses.
- RD_LAT, 2, feature-map BRAM read latency in cycles (>=1).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, level; begins a frame when sampled high in IDLE.
- kernel_ready, input, 1, kernel load complete; start is ignored while low.
- out_ready, input, 1, output path can accept a write this cycle.
- busy, output, 1, high from the first ISSUE cycle through the DONE cycle.
- done, output, 1, one-cycle pulse after the last output write.
- fmap_en, output, 1, feature-map read enable.
- fmap_addr, output, ADDR_W, feature-map read address.
- tap_valid, output, 1, BRAM data for tap tap_idx is present on douta this cycle.
- tap_idx, output, 4, patch slot 0..K*K-1, row-major.
- mac_ce, output, 1, one-cycle DSP clock-enable per window.
- out_wr_en, output, 1, output BRAM write strobe.
- out_addr, output, ADDR_W, output address = window index.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; row/col/tap/window counters 0.
- States and transitions:
  - IDLE -> ISSUE when start && kernel_ready.
  - ISSUE: K*K cycles, one address per cycle: fmap_addr = (row+ky)*IMG_W + col+kx, with kx as the fast index; fmap_en=1. Moves to DRAIN after tap K*K-1.
  - DRAIN: RD_LAT cycles, fmap_en=0.
  - ACC: 1 cycle, mac_ce=1.
  - WRITE: out_wr_en=1 and out_addr=window index.
    - Stays in WRITE while out_ready=0; out_addr is held.
    - Leaves when out_ready=1: to ISSUE for the next window, or to DONE after the last window.
  - DONE: done=1 for 1 cycle -> IDLE.
- tap_valid/tap_idx are a RD_LAT-deep delay line of the issue strobe/index. Tap i of a window is valid exactly RD_LAT cycles after its address is issued. All taps of a window are valid before ACC.
- Per-window latency with out_ready=1: K*K + RD_LAT + 2 cycles (13 at defaults).
- Window advance after each accepted write:
  - col++.
  - At col==IMG_W-K: col=0, row++.
  - The window after row==IMG_H-K, col==IMG_W-K does not exist; go to DONE instead.
- Window count = (IMG_W-K+1)*(IMG_H-K+1) = 49284 at defaults. Max fmap_addr = IMG_W*IMG_H-1 = 50175. Both fit 16 bits; a parameter combination overflowing ADDR_W is illegal.
- Addresses are computed incrementally (row base += IMG_W), with no multiplier.
- start while busy: ignored. start held high through DONE: a new frame begins on the cycle after returning to IDLE.
- kernel_ready falling mid-frame: ignored; only sampled in IDLE.
- Reset mid-frame: immediate return to IDLE. Any in-flight tap_valid and out_wr_en are deasserted asynchronously, and no partial write is issued after reset release.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, release with start=0 -> all outputs 0 for 10 cycles. Assert start with kernel_ready=0 -> busy stays 0.
- First window: default params, start=1, kernel_ready=1, out_ready=1.
  - fmap_addr sequence is 0,1,2,224,225,226,448,449,450 with fmap_en=1 for 9 cycles.
  - tap_valid with tap_idx 0..8 starts 2 cycles after the first address.
  - mac_ce fires in cycle 11, out_wr_en with out_addr=0 in cycle 12.
- Row wrap: window 221 base address 221; window 222 base address 224 with out_addr=222. Last window out_addr=49283, base 49725, final tap address 50175, followed by a 1-cycle done pulse.
- Small full frame: IMG_W=5, IMG_H=4, K=3 -> 6 writes to out_addr 0..5 at bases 0,1,2,5,6,7. done is asserted at cycle 6*13 after the first issue.
- Backpressure: drop out_ready for 4 cycles during window 3 -> out_wr_en held 5 cycles with out_addr=3 stable. No new fmap_en until out_ready=1. Window 4 then proceeds normally.
- Reset mid-frame: assert reset during window 10 DRAIN -> outputs 0 the same cycle. After release with start=1, addressing restarts at 0 and out_addr at 0.
